// File: rtl/wb_lat_mon.sv
// Wishbone beat-latency monitor: times each observed strobe->ack beat and keeps
// count/total/min/max/last/abort statistics behind a one-wait-state slave port.
// Optional macro LAT_MON_HIST_EN adds a four-bin latency histogram at 0x1C..0x28.
module wb_lat_mon #(
    parameter logic [31:0] BASE_ADR = 32'h99000100,
    parameter int          LAT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_adr,
    input  logic [31:0]      wb_dat_o,
    input  logic             wb_we,
    input  logic [3:0]       wb_sel,
    input  logic             wb_stb,
    input  logic             wb_cyc,
    output logic [31:0]      wb_dat_i,
    output logic             wb_ack,
    output logic             wb_err,
    output logic             wb_rty,
    input  logic             mon_stb,
    input  logic             mon_cyc,
    input  logic             mon_ack,
    output logic             txn_done,
    output logic [LAT_W-1:0] txn_lat
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cur_q, cur_d, cur_inc, lat_q, lat_d;
    logic             done_q, done_d, abort, mon_act;
    logic             en_q, en_d, ack_q, ack_d;
    logic [31:0]      count_q, count_d, total_q, total_d, aborts_q, aborts_d;
    logic [LAT_W-1:0] min_q, min_d, max_q, max_d, last_q, last_d;
    logic [31:0]      dat_q, dat_d, rdata;
    logic             hit, wr, clr;
    logic [5:0]       off;
    logic [32:0]      total_sum;
    logic             unused_ok;
`ifdef LAT_MON_HIST_EN
    logic [3:0][31:0] hist_q, hist_d;
    logic [1:0]       bin;
`endif

    assign unused_ok = ^{wb_adr[1:0], wb_sel, wb_dat_o[31:2]};

    assign mon_act = mon_stb && mon_cyc;
    assign cur_inc = (cur_q == LAT_MAX) ? LAT_MAX : cur_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        lat_d   = lat_q;
        done_d  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (mon_act) begin
                if (mon_ack) begin
                    done_d = 1'b1;
                    lat_d  = LAT_ONE;
                end else begin
                    state_d = BUSY;
                    cur_d   = LAT_ONE;
                end
            end
            BUSY: begin
                if (!mon_act) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cur_d   = '0;
                end else if (mon_ack) begin
                    done_d  = 1'b1;
                    lat_d   = cur_inc;
                    state_d = IDLE;
                    cur_d   = '0;
                end else begin
                    cur_d = cur_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave side: ack on the cycle after the request, writes land on the ack edge.
    assign hit   = (wb_adr[31:8] == BASE_ADR[31:8]);
    assign off   = wb_adr[7:2];
    assign ack_d = wb_stb && wb_cyc && !ack_q;
    assign wr    = ack_q && wb_stb && wb_cyc && wb_we && hit && (off == 6'd0);
    assign clr   = wr && wb_dat_o[1];

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                6'd0: rdata = {31'd0, en_q};
                6'd1: rdata = count_q;
                6'd2: rdata = total_q;
                6'd3: rdata = 32'(min_q);
                6'd4: rdata = 32'(max_q);
                6'd5: rdata = 32'(last_q);
                6'd6: rdata = aborts_q;
`ifdef LAT_MON_HIST_EN
                6'd7:  rdata = hist_q[0];
                6'd8:  rdata = hist_q[1];
                6'd9:  rdata = hist_q[2];
                6'd10: rdata = hist_q[3];
`endif
                default: rdata = '0;
            endcase
        end
    end
    assign dat_d = ack_d ? rdata : '0;

`ifdef LAT_MON_HIST_EN
    always_comb begin
        bin = 2'd3;
        if (lat_d == LAT_ONE)          bin = 2'd0;
        else if (32'(lat_d) <= 32'd4)  bin = 2'd1;
        else if (32'(lat_d) <= 32'd16) bin = 2'd2;
    end
`endif

    assign total_sum = {1'b0, total_q} + 33'(lat_d);

    // Clear has priority over a beat or abort landing on the same edge.
    always_comb begin
        en_d     = wr ? wb_dat_o[0] : en_q;
        count_d  = count_q;
        total_d  = total_q;
        min_d    = min_q;
        max_d    = max_q;
        last_d   = last_q;
        aborts_d = aborts_q;
`ifdef LAT_MON_HIST_EN
        hist_d   = hist_q;
`endif
        if (clr) begin
            count_d  = '0;
            total_d  = '0;
            min_d    = LAT_MAX;
            max_d    = '0;
            last_d   = '0;
            aborts_d = '0;
`ifdef LAT_MON_HIST_EN
            hist_d   = '0;
`endif
        end else if (en_q) begin
            if (done_d) begin
                count_d = count_q + 32'd1;
                total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
                if (lat_d < min_q) min_d = lat_d;
                if (lat_d > max_q) max_d = lat_d;
                last_d  = lat_d;
`ifdef LAT_MON_HIST_EN
                hist_d[bin] = hist_q[bin] + 32'd1;
`endif
            end
            if (abort) aborts_d = aborts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            lat_q    <= '0;
            done_q   <= 1'b0;
            en_q     <= 1'b1;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            count_q  <= '0;
            total_q  <= '0;
            min_q    <= LAT_MAX;
            max_q    <= '0;
            last_q   <= '0;
            aborts_q <= '0;
`ifdef LAT_MON_HIST_EN
            hist_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            lat_q    <= lat_d;
            done_q   <= done_d;
            en_q     <= en_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            count_q  <= count_d;
            total_q  <= total_d;
            min_q    <= min_d;
            max_q    <= max_d;
            last_q   <= last_d;
            aborts_q <= aborts_d;
`ifdef LAT_MON_HIST_EN
            hist_q   <= hist_d;
`endif
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_i = dat_q;
    assign wb_err   = 1'b0;
    assign wb_rty   = 1'b0;
    assign txn_done = done_q;
    assign txn_lat  = lat_q;
endmodule
